// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among NUM_REQ requesters.
// Bounded bursts per owner, one memory op per cycle, read data returned with a one-cycle rvalid pulse.
module sram_port_arbiter #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 8,
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = 4,
  localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       we,
  input  logic [NUM_REQ*AW-1:0]    addr,
  input  logic [NUM_REQ*WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       rvalid,
  output logic [WIDTH-1:0]         rdata,
  output logic                     busy,
  output logic                     mem_we,
  output logic [AW-1:0]            mem_addr,
  output logic [WIDTH-1:0]         mem_wdata,
  input  logic [WIDTH-1:0]         mem_rdata
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BURST_LEN + 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t                          state_q, state_d;
  logic [IW-1:0]                   owner_q, owner_d;
  logic [IW-1:0]                   last_q, last_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic                            win_vld;
  logic [IW-1:0]                   win;
  logic [IW:0]                     pick;
  logic [NUM_REQ-1:0]              others;
  logic                            go;
  logic [NUM_REQ-1:0][AW-1:0]      addr_a;
  logic [NUM_REQ-1:0][WIDTH-1:0]   wdata_a;
  logic [AW-1:0]                   addr_q;
  logic [WIDTH-1:0]                wdata_q;
  logic [NUM_REQ-1:0]              rvalid_q;
  logic                            busy_q;

  assign addr_a  = addr;
  assign wdata_a = wdata;

  // Returns {found, index} of the first set bit strictly after base, wrapping.
  function automatic logic [IW:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [IW-1:0] base);
    logic          found;
    logic [IW-1:0] idx;
    logic [IW-1:0] j;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = IW'((int'(base) + k) % NUM_REQ);
      if (!found && r[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
    return {found, idx};
  endfunction

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    win_vld = 1'b0;
    win     = owner_q;
    pick    = '0;
    others  = req & ~(NUM_REQ'(1) << owner_q);
    case (state_q)
      IDLE: begin
        pick = rr_pick(req, last_q);
        if (pick[IW]) begin
          win_vld = 1'b1;
          win     = pick[IW-1:0];
          cnt_d   = CW'(1);
        end
      end
      OWNED: begin
        if (req[owner_q] && (cnt_q < CW'(BURST_LEN))) begin
          win_vld = 1'b1;
          win     = owner_q;
          cnt_d   = cnt_q + 1'b1;
        end else if (req[owner_q] && !(|others)) begin
          // burst exhausted but nobody else waits: restart the burst without a bubble
          win_vld = 1'b1;
          win     = owner_q;
          cnt_d   = CW'(1);
        end else begin
          pick = rr_pick(others, owner_q);
          if (pick[IW]) begin
            win_vld = 1'b1;
            win     = pick[IW-1:0];
            cnt_d   = CW'(1);
          end
        end
      end
      default: ;
    endcase
    if (win_vld) begin
      owner_d = win;
      last_d  = win;
      state_d = (BURST_LEN == 1) ? IDLE : OWNED;
    end else begin
      state_d = IDLE;
    end
  end

  // Grant is suppressed while reset is held so nothing reaches the memory.
  assign go = win_vld & rst_n;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_gnt
    assign gnt[i] = go && (win == IW'(i));
  end

  assign mem_we    = go & we[win];
  assign mem_addr  = go ? addr_a[win]  : addr_q;
  assign mem_wdata = go ? wdata_a[win] : wdata_q;
  assign rvalid    = rvalid_q;
  assign rdata     = mem_rdata;
  assign busy      = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      last_q   <= IW'(NUM_REQ - 1);
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rvalid_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      if (go) begin
        addr_q  <= addr_a[win];
        wdata_q <= wdata_a[win];
      end
      rvalid_q <= (go && !we[win]) ? gnt : '0;
      busy_q   <= |(req & gnt);
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural single-port SRAM model.
module tb_sram_port_arbiter;
  localparam int WIDTH = 32, DEPTH = 8, NUM_REQ = 4, BURST_LEN = 4, AW = 3;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NUM_REQ-1:0]       req = '0;
  logic [NUM_REQ-1:0]       we = '0;
  logic [NUM_REQ*AW-1:0]    addr = '0;
  logic [NUM_REQ*WIDTH-1:0] wdata = '0;
  logic [NUM_REQ-1:0]       gnt, rvalid;
  logic [WIDTH-1:0]         rdata;
  logic                     busy, mem_we;
  logic [AW-1:0]            mem_addr;
  logic [WIDTH-1:0]         mem_wdata;
  logic [WIDTH-1:0]         mem_rdata = '0;
  logic [WIDTH-1:0]         mem [DEPTH];

  int n_chk = 0;
  int n_err = 0;

  logic [3:0]       t5_req [6];
  logic [2:0]       t5_a1 [6];
  logic [2:0]       t5_a3 [6];
  logic [3:0]       t5_gnt [6];
  logic [2:0]       t5_madr [6];
  logic [3:0]       t5_rv [6];
  logic [WIDTH-1:0] t5_rd [6];

  sram_port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_REQ(NUM_REQ), .BURST_LEN(BURST_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else        mem_rdata     <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int i, input logic w, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    we[i]                  = w;
    addr[i*AW +: AW]       = a;
    wdata[i*WIDTH +: WIDTH] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    t5_req  = '{4'b1010, 4'b1000, 4'b0010, 4'b1000, 4'b0000, 4'b0000};
    t5_a1   = '{3'd5, 3'd5, 3'd6, 3'd6, 3'd0, 3'd0};
    t5_a3   = '{3'd6, 3'd6, 3'd6, 3'd5, 3'd5, 3'd5};
    t5_gnt  = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0000, 4'b0000};
    t5_madr = '{3'd5, 3'd6, 3'd6, 3'd5, 3'd0, 3'd0};
    t5_rv   = '{4'b0000, 4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0000};
    t5_rd   = '{32'h0, 32'h55, 32'h66, 32'h66, 32'h55, 32'h0};

    // 1: reset holds everything quiet even with all requests up
    req = 4'b1111;
    we  = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_addr", mem_addr, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_first_gnt", gnt, 4'b0001);
    tick();
    req = '0;
    @(negedge clk);
    chk("rst_first_rvalid", rvalid, 4'b0001);
    chk("rst_busy_after", busy, 1);
    tick();

    // 2: single write then read-back by requester 0
    req = 4'b0001;
    set_port(0, 1'b1, 3'd3, 32'hDEADBEEF);
    @(negedge clk);
    chk("wr_gnt", gnt, 4'b0001);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 3);
    chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    set_port(0, 1'b0, 3'd3, 32'h0);
    @(negedge clk);
    chk("rd_gnt", gnt, 4'b0001);
    chk("rd_mem_we", mem_we, 0);
    chk("wr_no_rvalid", rvalid, 0);
    tick();
    req = '0;
    @(negedge clk);
    chk("rd_rvalid", rvalid, 4'b0001);
    chk("rd_rdata", rdata, 32'hDEADBEEF);
    chk("rd_busy", busy, 1);
    tick();
    @(negedge clk);
    chk("rd_rvalid_pulse", rvalid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_addr_hold", mem_addr, 3);
    chk("idle_mem_we", mem_we, 0);

    // 3: fairness with everyone requesting
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_port(i, 1'b0, AW'(i), '0);
    req = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk($sformatf("fair_gnt%0d", i), gnt, 4'b0001 << (i / 4));
      if (i > 0) chk($sformatf("fair_rv%0d", i), rvalid, 4'b0001 << ((i - 1) / 4));
      tick();
    end
    req = '0;
    @(negedge clk);
    chk("fair_last_rv", rvalid, 4'b0100);
    tick();

    // 4: owner drops mid-burst, waiting requester takes over
    req = 4'b0001;
    @(negedge clk);
    chk("brel_c0", gnt, 4'b0001);
    tick();
    req = 4'b0101;
    @(negedge clk);
    chk("brel_c1", gnt, 4'b0001);
    tick();
    req = 4'b0100;
    @(negedge clk);
    chk("brel_c2", gnt, 4'b0100);
    tick();
    @(negedge clk);
    chk("brel_c3", gnt, 4'b0100);
    tick();
    req = '0;
    tick();

    // 5: preload 5/6 through the arbiter, then interleaved reads
    do_reset();
    req = 4'b0010;
    set_port(1, 1'b1, 3'd5, 32'h55);
    @(negedge clk);
    chk("pre_gnt1", gnt, 4'b0010);
    tick();
    req = 4'b1000;
    set_port(3, 1'b1, 3'd6, 32'h66);
    @(negedge clk);
    chk("pre_gnt3", gnt, 4'b1000);
    tick();
    req = '0;
    tick();
    for (int c = 0; c < 6; c++) begin
      req = t5_req[c];
      set_port(1, 1'b0, t5_a1[c], '0);
      set_port(3, 1'b0, t5_a3[c], '0);
      @(negedge clk);
      chk($sformatf("b2b_gnt%0d", c), gnt, t5_gnt[c]);
      if (t5_gnt[c] != 0) chk($sformatf("b2b_addr%0d", c), mem_addr, t5_madr[c]);
      chk($sformatf("b2b_rv%0d", c), rvalid, t5_rv[c]);
      if (t5_rv[c] != 0) chk($sformatf("b2b_rd%0d", c), rdata, t5_rd[c]);
      tick();
    end

    // 6: reset right after a read grant discards the response
    req = 4'b0001;
    set_port(0, 1'b0, 3'd3, '0);
    @(negedge clk);
    chk("mid_gnt", gnt, 4'b0001);
    tick();
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk);
    chk("mid_rv_in_rst", rvalid, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rv_after", rvalid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_mem_addr", mem_addr, 0);
    tick();
    req = 4'b1111;
    @(negedge clk);
    chk("mid_first_gnt", gnt, 4'b0001);
    tick();
    req = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
